// File: rtl/hazard_ctrl.sv
// Hazard and control unit for the 5-stage RV32 pipeline: shadows the E/M/W
// destination/control bits and derives stall, flush and forwarding selects.
module hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter bit FWD_EN = 1'b1,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_d,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic              use_rs1_d,
    input  logic              use_rs2_d,
    input  logic [REG_AW-1:0] rd_d,
    input  logic              reg_write_d,
    input  logic [1:0]        result_src_d,
    input  logic              mem_write_d,
    input  logic              pc_src_e,
    input  logic              mem_ready_m,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              stall_m,
    output logic              flush_d,
    output logic              flush_e,
    output logic [1:0]        forward_a_e,
    output logic [1:0]        forward_b_e,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              reg_write;
        logic              is_load;
        logic              is_mem;
    } stage_t;

    localparam stage_t            STAGE_EMPTY = '{default: 1'b0};
    localparam logic [REG_AW-1:0] REG_ZERO    = {REG_AW{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    stage_t            e_r;
    stage_t            m_r;
    stage_t            w_r;
    logic [REG_AW-1:0] e_rs1_r;
    logic [REG_AW-1:0] e_rs2_r;
    logic              e_use_rs1_r;
    logic              e_use_rs2_r;

    stage_t            d_s;
    logic              mem_busy_s;
    logic              branch_s;
    logic              dep_e_s;
    logic              dep_m_s;
    logic              raw_stall_s;

    // A stage only produces a usable result when valid, writing, and not targeting x0.
    function automatic logic writes_reg(input stage_t s);
        return s.valid & s.reg_write & (s.rd != REG_ZERO);
    endfunction

    function automatic logic reads_reg(input logic [REG_AW-1:0] rd,
                                       input logic              use1,
                                       input logic [REG_AW-1:0] rs1,
                                       input logic              use2,
                                       input logic [REG_AW-1:0] rs2);
        return (use1 & (rs1 == rd)) | (use2 & (rs2 == rd));
    endfunction

    function automatic logic [1:0] fwd_sel(input stage_t            m,
                                           input stage_t            w,
                                           input logic              use_rs,
                                           input logic [REG_AW-1:0] rs);
        logic [1:0] sel;
        sel = 2'b00;
        if (use_rs && writes_reg(m) && (m.rd == rs)) begin
            sel = 2'b10;
        end else if (use_rs && writes_reg(w) && (w.rd == rs)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    assign d_s.valid     = valid_d;
    assign d_s.rd        = rd_d;
    assign d_s.reg_write = reg_write_d;
    assign d_s.is_load   = (result_src_d == 2'b01);
    assign d_s.is_mem    = (result_src_d == 2'b01) | mem_write_d;

    // Raw hazard terms from shadow state and decode-stage inputs.
    always_comb begin
        mem_busy_s = m_r.valid & m_r.is_mem & ~mem_ready_m;
        branch_s   = e_r.valid & pc_src_e;
        dep_e_s    = valid_d & writes_reg(e_r)
                   & reads_reg(e_r.rd, use_rs1_d, rs1_d, use_rs2_d, rs2_d);
        dep_m_s    = valid_d & writes_reg(m_r)
                   & reads_reg(m_r.rd, use_rs1_d, rs1_d, use_rs2_d, rs2_d);
        if (FWD_EN) begin
            raw_stall_s = dep_e_s & e_r.is_load;
        end else begin
            raw_stall_s = dep_e_s | dep_m_s;
        end
    end

    // Prioritised stall/flush decision and forwarding selects.
    always_comb begin
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        stall_e     = 1'b0;
        stall_m     = 1'b0;
        flush_d     = 1'b0;
        flush_e     = 1'b0;
        forward_a_e = 2'b00;
        forward_b_e = 2'b00;
        if (mem_busy_s) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
        end else if (branch_s) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (raw_stall_s) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end else begin
            stall_f = 1'b0;
        end
        if (FWD_EN) begin
            forward_a_e = fwd_sel(m_r, w_r, e_use_rs1_r, e_rs1_r);
            forward_b_e = fwd_sel(m_r, w_r, e_use_rs2_r, e_rs2_r);
        end else begin
            forward_a_e = 2'b00;
            forward_b_e = 2'b00;
        end
    end

    // Shadow pipeline advance; everything freezes while the data memory is busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_r         <= STAGE_EMPTY;
            m_r         <= STAGE_EMPTY;
            w_r         <= STAGE_EMPTY;
            e_rs1_r     <= REG_ZERO;
            e_rs2_r     <= REG_ZERO;
            e_use_rs1_r <= 1'b0;
            e_use_rs2_r <= 1'b0;
        end else if (!mem_busy_s) begin
            w_r <= m_r;
            m_r <= e_r;
            if (flush_e) begin
                e_r         <= STAGE_EMPTY;
                e_rs1_r     <= REG_ZERO;
                e_rs2_r     <= REG_ZERO;
                e_use_rs1_r <= 1'b0;
                e_use_rs2_r <= 1'b0;
            end else begin
                e_r         <= d_s;
                e_rs1_r     <= rs1_d;
                e_rs2_r     <= rs2_d;
                e_use_rs1_r <= use_rs1_d;
                e_use_rs2_r <= use_rs2_d;
            end
        end else begin
            w_r <= w_r;
            m_r <= m_r;
            e_r <= e_r;
        end
    end

    // Performance counters, wrapping naturally at the counter width.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= CNT_ZERO;
            flush_cnt <= CNT_ZERO;
        end else begin
            if (stall_f) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end else begin
                stall_cnt <= stall_cnt;
            end
            if (flush_d) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end else begin
                flush_cnt <= flush_cnt;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: one forwarding instance and one
// interlock-only instance, each with its own expected-response queue.
module tb_hazard_ctrl;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
        logic [4:0] rd;
        logic       rw;
        logic [1:0] rsrc;
        logic       mw;
        logic       pc_src;
        logic       mem_ready;
    } in_t;

    typedef struct packed {
        logic [63:0] tag;
        logic [9:0]  ctl;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    // ctl = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, fwd_a[1:0], fwd_b[1:0]}
    localparam logic [9:0] Z   = 10'b0000000000;
    localparam logic [9:0] STL = 10'b1100010000;
    localparam logic [9:0] FLS = 10'b0000110000;
    localparam logic [9:0] MEM = 10'b1111000000;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic probe = 1'b0;
    in_t  in0;
    in_t  in1;

    logic        sf0, sd0, se0, sm0, fd0, fe0;
    logic [1:0]  fa0, fb0;
    logic [31:0] sc0, fc0;
    logic        sf1, sd1, se1, sm1, fd1, fe1;
    logic [1:0]  fa1, fb1;
    logic [31:0] sc1, fc1;
    logic [9:0]  ctl0, ctl1;

    exp_t        q0[$];
    exp_t        q1[$];
    exp_t        pop0;
    exp_t        pop1;
    int          total = 0;
    int          bad   = 0;
    logic [31:0] es0 = 32'd0, ef0 = 32'd0, es1 = 32'd0, ef1 = 32'd0;

    assign ctl0 = {sf0, sd0, se0, sm0, fd0, fe0, fa0, fb0};
    assign ctl1 = {sf1, sd1, se1, sm1, fd1, fe1, fa1, fb1};

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_AW(5), .FWD_EN(1'b1), .CNT_W(32)) dut_fwd (
        .clk(clk), .rst(rst),
        .valid_d(in0.valid), .rs1_d(in0.rs1), .rs2_d(in0.rs2),
        .use_rs1_d(in0.use1), .use_rs2_d(in0.use2), .rd_d(in0.rd),
        .reg_write_d(in0.rw), .result_src_d(in0.rsrc), .mem_write_d(in0.mw),
        .pc_src_e(in0.pc_src), .mem_ready_m(in0.mem_ready),
        .stall_f(sf0), .stall_d(sd0), .stall_e(se0), .stall_m(sm0),
        .flush_d(fd0), .flush_e(fe0), .forward_a_e(fa0), .forward_b_e(fb0),
        .stall_cnt(sc0), .flush_cnt(fc0)
    );

    hazard_ctrl #(.REG_AW(5), .FWD_EN(1'b0), .CNT_W(32)) dut_nofwd (
        .clk(clk), .rst(rst),
        .valid_d(in1.valid), .rs1_d(in1.rs1), .rs2_d(in1.rs2),
        .use_rs1_d(in1.use1), .use_rs2_d(in1.use2), .rd_d(in1.rd),
        .reg_write_d(in1.rw), .result_src_d(in1.rsrc), .mem_write_d(in1.mw),
        .pc_src_e(in1.pc_src), .mem_ready_m(in1.mem_ready),
        .stall_f(sf1), .stall_d(sd1), .stall_e(se1), .stall_m(sm1),
        .flush_d(fd1), .flush_e(fe1), .forward_a_e(fa1), .forward_b_e(fb1),
        .stall_cnt(sc1), .flush_cnt(fc1)
    );

    function automatic in_t nop();
        in_t x;
        x = '0;
        x.mem_ready = 1'b1;
        return x;
    endfunction

    function automatic in_t alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        in_t x;
        x = nop();
        x.valid = 1'b1; x.rd = rd; x.rs1 = rs1; x.rs2 = rs2;
        x.use1 = 1'b1; x.use2 = 1'b1; x.rw = 1'b1;
        return x;
    endfunction

    function automatic in_t lw(input logic [4:0] rd, input logic [4:0] rs1);
        in_t x;
        x = nop();
        x.valid = 1'b1; x.rd = rd; x.rs1 = rs1; x.use1 = 1'b1;
        x.rw = 1'b1; x.rsrc = 2'b01;
        return x;
    endfunction

    function automatic in_t sw(input logic [4:0] rs1, input logic [4:0] rs2);
        in_t x;
        x = nop();
        x.valid = 1'b1; x.rs1 = rs1; x.rs2 = rs2;
        x.use1 = 1'b1; x.use2 = 1'b1; x.mw = 1'b1;
        return x;
    endfunction

    function automatic in_t beq(input logic [4:0] rs1, input logic [4:0] rs2);
        in_t x;
        x = nop();
        x.valid = 1'b1; x.rs1 = rs1; x.rs2 = rs2;
        x.use1 = 1'b1; x.use2 = 1'b1;
        return x;
    endfunction

    function automatic in_t with_ex(input in_t d, input logic pc, input logic mr);
        in_t x;
        x = d;
        x.pc_src = pc;
        x.mem_ready = mr;
        return x;
    endfunction

    task automatic check(input exp_t e, input logic [9:0] c, input logic [31:0] s, input logic [31:0] f);
        total = total + 1;
        if ({c, s, f} !== {e.ctl, e.sc, e.fc}) begin
            bad = bad + 1;
            $display("FAIL %s: got ctl=%b stall_cnt=%0d flush_cnt=%0d, want ctl=%b stall_cnt=%0d flush_cnt=%0d",
                     e.tag, c, s, f, e.ctl, e.sc, e.fc);
        end
    endtask

    task automatic push0(input logic [9:0] c, input logic [63:0] tag);
        exp_t e;
        e.tag = tag; e.ctl = c; e.sc = es0; e.fc = ef0;
        q0.push_back(e);
        es0 = es0 + {31'd0, c[9]};
        ef0 = ef0 + {31'd0, c[5]};
    endtask

    task automatic push1(input logic [9:0] c, input logic [63:0] tag);
        exp_t e;
        e.tag = tag; e.ctl = c; e.sc = es1; e.fc = ef1;
        q1.push_back(e);
        es1 = es1 + {31'd0, c[9]};
        ef1 = ef1 + {31'd0, c[5]};
    endtask

    task automatic drive0(input in_t x, input logic [9:0] c, input logic [63:0] tag);
        @(posedge clk);
        #1;
        in0 = x;
        push0(c, tag);
    endtask

    task automatic drive1(input in_t x, input logic [9:0] c, input logic [63:0] tag);
        @(posedge clk);
        #1;
        in1 = x;
        push1(c, tag);
    endtask

    // Monitor for the forwarding instance; probe allows a mid-cycle sample.
    always @(negedge clk or posedge probe) begin
        if (q0.size() > 0) begin
            pop0 = q0.pop_front();
            check(pop0, ctl0, sc0, fc0);
        end
    end

    // Monitor for the interlock-only instance.
    always @(negedge clk) begin
        if (q1.size() > 0) begin
            pop1 = q1.pop_front();
            check(pop1, ctl1, sc1, fc1);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "timeout");
    end

    initial begin
        in0 = nop();
        in1 = nop();
        drive0(nop(), Z, "rst_f");
        drive1(nop(), Z, "rst_n");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // forwarding from M then W
        drive0(alu(5'd5, 5'd1, 5'd2), Z, "fw_add");
        drive0(alu(5'd6, 5'd5, 5'd3), Z, "fw_sub");
        drive0(alu(5'd7, 5'd5, 5'd6), 10'b0000001000, "fw_m");
        drive0(nop(), 10'b0000000110, "fw_wm");
        repeat (3) drive0(nop(), Z, "fw_drn");

        // load-use
        drive0(lw(5'd5, 5'd1), Z, "lu_lw");
        drive0(alu(5'd6, 5'd5, 5'd5), STL, "lu_stl");
        drive0(alu(5'd6, 5'd5, 5'd5), Z, "lu_bub");
        drive0(nop(), 10'b0000000101, "lu_fw");
        repeat (3) drive0(nop(), Z, "lu_drn");

        // branch beats load-use, then x0 never hazards
        drive0(lw(5'd5, 5'd1), Z, "br_lw");
        drive0(with_ex(alu(5'd6, 5'd5, 5'd5), 1'b1, 1'b1), FLS, "br_fls");
        drive0(nop(), Z, "br_aft");
        drive0(lw(5'd0, 5'd1), Z, "x0_lw");
        drive0(alu(5'd6, 5'd0, 5'd0), Z, "x0_use");
        drive0(nop(), Z, "x0_fwd");
        repeat (2) drive0(nop(), Z, "x0_drn");

        // data-memory stall with a taken branch waiting in E
        drive0(sw(5'd1, 5'd2), Z, "ms_sw");
        drive0(beq(5'd3, 5'd4), Z, "ms_beq");
        repeat (3) drive0(with_ex(alu(5'd8, 5'd1, 5'd2), 1'b1, 1'b0), MEM, "ms_busy");
        drive0(with_ex(alu(5'd8, 5'd1, 5'd2), 1'b1, 1'b1), FLS, "ms_fls");
        repeat (3) drive0(nop(), Z, "ms_drn");

        // asynchronous reset in the middle of a load-use stall
        drive0(lw(5'd5, 5'd1), Z, "rs_lw");
        drive0(alu(5'd6, 5'd5, 5'd5), STL, "rs_stl");
        #6;
        rst = 1'b1;
        es0 = 32'd0; ef0 = 32'd0; es1 = 32'd0; ef1 = 32'd0;
        push0(Z, "rs_mid");
        #1 probe = 1'b1;
        #1 probe = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in0 = nop();
        drive0(nop(), Z, "rs_post");

        // interlock-only instance
        drive1(alu(5'd5, 5'd1, 5'd2), Z, "nf_add");
        drive1(alu(5'd6, 5'd5, 5'd3), STL, "nf_stE");
        drive1(alu(5'd6, 5'd5, 5'd3), STL, "nf_stM");
        drive1(alu(5'd6, 5'd5, 5'd3), Z, "nf_go");
        drive1(nop(), Z, "nf_sub");
        drive1(alu(5'd7, 5'd1, 5'd2), Z, "nf_add7");
        drive1(nop(), Z, "nf_gap");
        drive1(alu(5'd8, 5'd7, 5'd7), STL, "nf_stM2");
        drive1(alu(5'd8, 5'd7, 5'd7), Z, "nf_go2");
        drive1(nop(), Z, "nf_e");
        drive1(nop(), Z, "nf_end");

        repeat (3) @(posedge clk);
        total = total + 1;
        if ((q0.size() != 0) || (q1.size() != 0)) begin
            bad = bad + 1;
            $display("FAIL drain: got pending=%0d/%0d, want 0/0", q0.size(), q1.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Parametrised pipeline hazard and control unit for the 5-stage RV32 core (fetch/decode/execute/memory/writeback).
- Keeps its own shadow copy of the destination and control bits of the instructions in the E, M and W stages.
- From these it generates stall, flush (bubble) and forwarding selects. Covers load-use stalls, taken-branch/jump flushes, multi-cycle data-memory stalls, and an optional no-forwarding mode.
- Carries performance counters for stall cycles and flushes.

Parameters:
REG_AW, 5, register address width
FWD_EN, 1, 1 = forwarding from M/W enabled; 0 = interlock-only (stall on any RAW against E or M)
CNT_W, 32, performance counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
valid_d  in  1  decode-stage instruction valid
rs1_d  in  REG_AW  decode source 1
rs2_d  in  REG_AW  decode source 2
use_rs1_d  in  1  instruction reads rs1
use_rs2_d  in  1  instruction reads rs2
rd_d  in  REG_AW  decode destination
reg_write_d  in  1  decode RegWrite
result_src_d  in  2  decode ResultSrc (2'b01 = load)
mem_write_d  in  1  decode MemWrite
pc_src_e  in  1  taken branch/jump resolved in E
mem_ready_m  in  1  data memory has completed the M-stage access
stall_f  out  1  hold PC
stall_d  out  1  hold F/D register
stall_e  out  1  hold D/E register
stall_m  out  1  hold E/M and M/W registers
flush_d  out  1  clear F/D register to bubble
flush_e  out  1  clear D/E register to bubble
forward_a_e  out  2  ALU src A select: 00 reg, 01 ResultW, 10 ALUResultM
forward_b_e  out  2  ALU src B select, same encoding
stall_cnt  out  CNT_W  cycles with stall_f asserted
flush_cnt  out  CNT_W  cycles with flush_d asserted

Behaviour:
- Reset (async, rst=1):
  - All shadow valid bits 0; shadow rd fields 0; counters 0.
  - All outputs 0; forward selects 00. Reset mid-stall cancels the stall immediately.
- Shadow pipe entries:
  - E, M and W entries each hold {valid, rd, reg_write, is_load, is_mem}.
  - E additionally holds rs1 and rs2, each with its use bit.
  - Writes to x0 are ignored: reg_write is qualified by rd!=0 wherever it is used.
- Hazard terms:
  - mem_busy = valid_m & is_mem_m & ~mem_ready_m.
  - branch = valid_e & pc_src_e.
  - dep(X) = valid_X & reg_write_X & rd_X!=0 & valid_d & ((use_rs1_d & rs1_d==rd_X) | (use_rs2_d & rs2_d==rd_X)).
  - raw_stall = dep(E) & is_load_e when FWD_EN=1; dep(E) | dep(M) when FWD_EN=0.
  - The register file is write-before-read, so W never causes a stall.
- Priority: mem_busy > branch > raw_stall.
  - mem_busy: stall_f = stall_d = stall_e = stall_m = 1; flush_d = flush_e = 0; shadow entries all hold. A branch sitting in E is honoured on the first cycle after mem_busy drops.
  - branch: flush_d = flush_e = 1; stall_f = stall_d = 0. The redirect wins over any raw_stall.
  - raw_stall: stall_f = stall_d = 1, flush_e = 1 (bubble into E); stall_e = stall_m = 0.
- All control outputs are combinational from the current shadow state and inputs; they are valid in the same cycle.
- Shadow update each rising edge, unless mem_busy:
  - W <= M; M <= E.
  - E <= bubble (valid=0) if flush_e, else the D fields with valid=valid_d.
- Forwarding (E-stage sources, FWD_EN=1):
  - Select 10 if valid_m & reg_write_m & rd_m!=0 & rd_m==rs_e & use_rs_e.
  - Otherwise 01 on the same match against W.
  - Otherwise 00.
  - M takes precedence over W. A load in M is never forwarded from M; the load-use stall guarantees this.
  - With FWD_EN=0, both selects are tied to 00.
- Counters:
  - stall_cnt increments on every cycle with stall_f=1, including mem_busy cycles.
  - flush_cnt increments on every cycle with flush_d=1.
  - Both wrap modulo 2^CNT_W.

Test Plan:
- Reset: assert rst asynchronously mid-cycle during a load-use stall -> all outputs 0 and counters 0 immediately, before the next clock edge.
- Forward M/W:
  - Sequence: add x5,x1,x2; then sub x6,x5,x3; then or x7,x5,x6.
  - sub in E -> forward_a_e=10.
  - or in E -> forward_a_e=01, forward_b_e=10.
  - No stalls.
- Load-use: lw x5,0(x1) followed by add x6,x5,x5 -> exactly 1 cycle with stall_f=stall_d=flush_e=1; next cycle forward_a_e=forward_b_e=01; stall_cnt=1.
- Branch vs load-use:
  - Setup: pc_src_e=1 in the same cycle as a load-use condition.
  - Response: flush_d=flush_e=1, stall_f=0; flush_cnt=1.
  - Write to x0 followed by a read of x0 -> no forward, no stall.
- Mem stall:
  - Stimulus: sw in M with mem_ready_m=0 for 3 cycles, while a taken branch sits in E.
  - During the 3 cycles: stall_* all 1, no flush.
  - Cycle 4: flush_d=flush_e=1; stall_cnt=3.
- FWD_EN=0: add x5 followed by sub using x5 -> 2 stall cycles; forward selects always 00.
